alsu_rr_scheduler: RTL and testbench
====================================

// Module: alsu_rr_scheduler
// PURPOSE
//  Shares one ALSU instance between NUM_REQ requesters using round-robin arbitration.
//  Accepts at most one command per cycle and drives the ALSU input pins from registers.
//  Tracks in-flight commands through the fixed ALSU latency and returns each result tagged with its requester id.
//  Supports a flush/drain handshake for reconfiguration.
// PARAMETERS
//  NUM_REQ   4  number of requesters (2..8)
//  ALSU_LAT  2  ALSU pipeline depth, from input pins to out (input reg + output reg)
//  ID_W      $clog2(NUM_REQ)  requester id width (derived, localparam)
// PORTS
//  clk          in   1           clock
//  rst          in   1           async active-high reset
//  req_valid    in   NUM_REQ     per-requester command valid
//  req_ready    out  NUM_REQ     per-requester accept (one-hot or zero)
//  req_opcode   in   NUM_REQ*3   opcode per requester
//  req_a/req_b  in   NUM_REQ*3   signed operands
//  req_cin      in   NUM_REQ*2   carry-in
//  req_flags    in   NUM_REQ*6   {red_op_A,red_op_B,bypass_A,bypass_B,direction,serial_in}
//  alsu_opcode/a/b/cin/flags  out  3/3/3/2/6  registered drive to ALSU inputs
//  alsu_out     in   6           ALSU result
//  rsp_valid    out  1           result strobe, one cycle, no backpressure
//  rsp_id       out  ID_W        requester that owns rsp_data
//  rsp_data     out  6           signed result
//  rsp_err      out  1           command was an ALSU-invalid combination
//  flush_req    in   1           level; stop granting and drain
//  flush_done   out  1           high while drained and flush_req is held
// BEHAVIOUR
//  Reset values: all outputs 0, state RUN, rr pointer = NUM_REQ-1 (requester 0 wins first), in-flight pipe cleared.
//  Handshake: transfer on req_valid[i] & req_ready[i].
//   req_ready is combinational from req_valid, the pointer and the state.
//   At most one bit of req_ready is set, and only in state RUN.
//  Arbitration: search starts at ptr+1 and wraps modulo NUM_REQ. Pointer updates to the granted index on transfer only.
//  Issue: the accepted command is registered onto alsu_* on the acceptance edge E0.
//   Cycles with no grant drive the idle NOP: bypass_A=1, A=0, others 0.
//  Tracking: shift register of {valid,id,err}, depth ALSU_LAT+1, advances every cycle.
//   rsp_* is registered from alsu_out at edge E0+ALSU_LAT+1 (E3 for default).
//   Back-to-back accepts give back-to-back rsp_valid in acceptance order.
//  Error: err = ~bypA & ~bypB & (((redA|redB) & (op[1]|op[2])) | (op[1]&op[2])).
//   rsp_data is whatever the ALSU returns (0 for a non-bypassed invalid command).
//  FSM states:
//   RUN: granting.
//   DRAIN: no grants; exits when the tracking pipe is empty.
//   HOLD: flush_done=1.
//  FSM transitions:
//   RUN -> DRAIN on flush_req. A grant in the same cycle as the flush_req rise is suppressed.
//   DRAIN -> HOLD when the pipe is empty (pipe already empty: DRAIN lasts 1 cycle).
//   HOLD -> RUN when flush_req falls. flush_done drops in the same cycle (combinational on state & flush_req).
//   flush_req dropping during DRAIN: complete the drain, then go straight to RUN.
//  Reset mid-operation: in-flight tags are discarded and no rsp_valid is emitted for them.
//  Simultaneous valid from all requesters: strict rotation, each granted once per NUM_REQ cycles.
// CONFIGURATION
//  `ALSU_SCHED_ERR_FILTER_EN defined:
//   Invalid commands are accepted but not issued (NOP driven instead).
//   Their response is returned with rsp_err=1 and rsp_data=0 at the same latency as normal commands.
//  Undefined: invalid commands are issued to the ALSU as-is, and rsp_err only flags them.
// STRUCTURE
//  Package alsu_sched_pkg:
//   opcode_e (OR, XOR, ADD, MUL, SHIFT, ROTATE, INV6, INV7);
//   alsu_cmd_t struct {opcode, a, b, cin, flags};
//   sched_state_e {RUN, DRAIN, HOLD};
//   NOP_CMD constant;
//   function is_invalid(alsu_cmd_t).
//  Sub-module rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant + index.
// TESTING
//  1. Reset, then req0 sends OR A=3'b010 B=3'b001 -> rsp_valid 3 cycles after accept, id=0, data=6'd3, err=0.
//  2. All 4 requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp ids follow the same order, back-to-back.
//  3. Opcode ADD with red_op_A=1 from req2 -> rsp id=2, err=1, data=0 (both macro settings).
//     Same command with bypass_A=1, A=3 -> err=0, data=3.
//  4. flush_req rises with 2 commands in flight -> no grants; flush_done rises after the 2 responses are out; flush_req low -> grants resume.
//  5. rst pulse 1 cycle after an accept -> no rsp_valid follows; next accept goes to requester 0.
//  6. Only req3 valid, then req1 -> grant 3 then 1 (wrap from pointer 3), each with single-cycle req_ready.

Source files
------------

// File: rtl/alsu_sched_pkg.sv
// Shared types, constants and the invalid-command predicate for the ALSU round-robin scheduler.
package alsu_sched_pkg;

  typedef enum logic [2:0] {
    OpOr, OpXor, OpAdd, OpMul, OpShift, OpRotate, OpInv6, OpInv7
  } opcode_e;

  typedef struct packed {
    opcode_e           opcode;
    logic signed [2:0] a;
    logic signed [2:0] b;
    logic [1:0]        cin;
    logic [5:0]        flags;  // {red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in}
  } alsu_cmd_t;

  typedef enum logic [1:0] {StRun, StDrain, StHold} sched_state_e;

  localparam int unsigned FlagRedA = 5;
  localparam int unsigned FlagRedB = 4;
  localparam int unsigned FlagBypA = 3;
  localparam int unsigned FlagBypB = 2;

  // Bypassing an all-zero A makes the ALSU output 0 without touching its state.
  localparam alsu_cmd_t NopCmd = '{
    opcode: OpOr, a: 3'sd0, b: 3'sd0, cin: 2'b00, flags: 6'b001000
  };

  function automatic logic is_invalid(alsu_cmd_t cmd);
    logic [2:0] op;
    logic       red;
    op  = cmd.opcode;
    red = cmd.flags[FlagRedA] | cmd.flags[FlagRedB];
    return ~cmd.flags[FlagBypA] & ~cmd.flags[FlagBypB] &
           ((red & (op[1] | op[2])) | (op[1] & op[2]));
  endfunction

endpackage

// File: rtl/alsu_rr_scheduler_if.sv
// Requester, ALSU-pin, response and flush signals of the ALSU round-robin scheduler.
interface alsu_rr_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*3-1:0] req_opcode;
  logic [NUM_REQ*3-1:0] req_a;
  logic [NUM_REQ*3-1:0] req_b;
  logic [NUM_REQ*2-1:0] req_cin;
  logic [NUM_REQ*6-1:0] req_flags;

  logic [2:0] alsu_opcode;
  logic [2:0] alsu_a;
  logic [2:0] alsu_b;
  logic [1:0] alsu_cin;
  logic [5:0] alsu_flags;
  logic [5:0] alsu_out;

  logic            rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic [5:0]      rsp_data;
  logic            rsp_err;

  logic flush_req;
  logic flush_done;

  // Environment side: requesters plus the ALSU itself.
  modport master (
    output req_valid, req_opcode, req_a, req_b, req_cin, req_flags, alsu_out, flush_req,
    input  req_ready, alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_flags,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, flush_done
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_cin, req_flags, alsu_out, flush_req,
    output req_ready, alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_flags,
    output rsp_valid, rsp_id, rsp_data, rsp_err, flush_done
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr_i and wraps modulo NUM_REQ.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  logic [ID_W-1:0] cand [NUM_REQ];
  logic            found;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand[i] = ID_W'((32'(ptr_i) + i + 32'd1) % NUM_REQ);
    end
  end

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[cand[i]]) begin
        found          = 1'b1;
        idx_o          = cand[i];
        gnt_o[cand[i]] = 1'b1;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/alsu_rr_scheduler.sv
// Round-robin sharing of one ALSU between NUM_REQ requesters with tagged responses and flush/drain.
// Optional: `ALSU_SCHED_ERR_FILTER_EN replaces invalid commands by a NOP and zeroes their data.
module alsu_rr_scheduler
  import alsu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ALSU_LAT = 2
) (
  input logic                clk,
  input logic                rst,
  alsu_rr_scheduler_if.slave bus
);

  localparam int unsigned ID_W      = $clog2(NUM_REQ);
  localparam int unsigned PipeDepth = ALSU_LAT + 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            err;
  } tag_t;

  sched_state_e       state_q, state_d;
  logic [ID_W-1:0]    ptr_q;
  alsu_cmd_t          cmd [NUM_REQ];
  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_valid;
  logic               grant_en;
  logic               fire;
  alsu_cmd_t          sel_cmd;
  logic               sel_err;
  alsu_cmd_t          issue_cmd;
  alsu_cmd_t          alsu_q;
  tag_t               pipe_q [PipeDepth];
  tag_t               pipe_out;
  logic               pipe_empty;
  logic [5:0]         rsp_data_d;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [5:0]         rsp_data_q;
  logic               rsp_err_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd[i].opcode = opcode_e'(bus.req_opcode[3*i +: 3]);
      cmd[i].a      = bus.req_a[3*i +: 3];
      cmd[i].b      = bus.req_b[3*i +: 3];
      cmd[i].cin    = bus.req_cin[2*i +: 2];
      cmd[i].flags  = bus.req_flags[6*i +: 6];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Gating on flush_req directly suppresses a grant in the cycle flush rises.
  assign grant_en      = (state_q == StRun) && !bus.flush_req;
  assign fire          = grant_en && arb_valid;
  assign bus.req_ready = grant_en ? arb_gnt : '0;

  assign sel_cmd = cmd[arb_idx];
  assign sel_err = is_invalid(sel_cmd);

  always_comb begin
    issue_cmd = NopCmd;
    if (fire) begin
`ifdef ALSU_SCHED_ERR_FILTER_EN
      if (!sel_err) issue_cmd = sel_cmd;
`else
      issue_cmd = sel_cmd;
`endif
    end
  end

  assign pipe_out = pipe_q[PipeDepth-1];

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < PipeDepth; i++) begin
      if (pipe_q[i].valid) pipe_empty = 1'b0;
    end
  end

  always_comb begin
    rsp_data_d = '0;
    if (pipe_out.valid) begin
`ifdef ALSU_SCHED_ERR_FILTER_EN
      rsp_data_d = pipe_out.err ? 6'd0 : bus.alsu_out;
`else
      rsp_data_d = bus.alsu_out;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (bus.flush_req) state_d = StDrain;
      StDrain: if (pipe_empty) state_d = bus.flush_req ? StHold : StRun;
      StHold:  if (!bus.flush_req) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      alsu_q      <= '0;
      for (int i = 0; i < PipeDepth; i++) pipe_q[i] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fire) ptr_q <= arb_idx;
      alsu_q    <= issue_cmd;
      pipe_q[0] <= '{valid: fire, id: (fire ? arb_idx : '0), err: fire & sel_err};
      for (int i = 1; i < PipeDepth; i++) pipe_q[i] <= pipe_q[i-1];
      rsp_valid_q <= pipe_out.valid;
      rsp_id_q    <= pipe_out.id;
      rsp_err_q   <= pipe_out.err;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.alsu_opcode = alsu_q.opcode;
  assign bus.alsu_a      = alsu_q.a;
  assign bus.alsu_b      = alsu_q.b;
  assign bus.alsu_cin    = alsu_q.cin;
  assign bus.alsu_flags  = alsu_q.flags;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.flush_done = (state_q == StHold) && bus.flush_req;

endmodule

// File: tb/tb_alsu_rr_scheduler.sv
// Directed bench for alsu_rr_scheduler with a two-stage behavioural ALSU behind it.
module tb_alsu_rr_scheduler;
  import alsu_sched_pkg::*;

  localparam int unsigned NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alsu_rr_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  alsu_rr_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .ALSU_LAT (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALSU: input register then output register.
  alsu_cmd_t  m_in;
  logic [5:0] m_out;

  function automatic logic [5:0] sx(input logic [2:0] v);
    return {{3{v[2]}}, v};
  endfunction

  function automatic logic [5:0] alsu_model(input alsu_cmd_t c);
    logic [2:0] op;
    logic       bad;
    op  = c.opcode;
    bad = ((c.flags[5] | c.flags[4]) & (op[1] | op[2])) | (op[1] & op[2]);
    if (c.flags[3]) return sx(c.a);
    if (c.flags[2]) return sx(c.b);
    if (bad) return 6'd0;
    case (op)
      3'd0:    return c.flags[5] ? {5'd0, |c.a} : c.flags[4] ? {5'd0, |c.b} : sx(c.a | c.b);
      3'd1:    return c.flags[5] ? {5'd0, ^c.a} : c.flags[4] ? {5'd0, ^c.b} : sx(c.a ^ c.b);
      3'd2:    return sx(c.a) + sx(c.b) + {4'd0, c.cin};
      3'd3:    return sx(c.a) * sx(c.b);
      default: return 6'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in  <= '0;
      m_out <= '0;
    end else begin
      m_in  <= '{opcode: opcode_e'(bus.alsu_opcode), a: bus.alsu_a, b: bus.alsu_b,
                 cin: bus.alsu_cin, flags: bus.alsu_flags};
      m_out <= alsu_model(m_in);
    end
  end
  assign bus.alsu_out = m_out;

  // Grant and response logs, sampled on the falling edge.
  int cyc = 0;
  int gnt_q[$];
  int rsp_id_q[$];
  int rsp_data_q[$];
  int rsp_err_q[$];
  int rsp_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) gnt_q.push_back(i);
      if (bus.rsp_valid) begin
        rsp_id_q.push_back(int'(bus.rsp_id));
        rsp_data_q.push_back(int'(bus.rsp_data));
        rsp_err_q.push_back(int'(bus.rsp_err));
        rsp_cyc_q.push_back(cyc);
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic [2:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic [1:0] cin, input logic [5:0] flags);
    bus.req_opcode[3*r +: 3] = op;
    bus.req_a[3*r +: 3]      = a;
    bus.req_b[3*r +: 3]      = b;
    bus.req_cin[2*r +: 2]    = cin;
    bus.req_flags[6*r +: 6]  = flags;
  endtask

  task automatic clear_logs();
    gnt_q.delete();
    rsp_id_q.delete();
    rsp_data_q.delete();
    rsp_err_q.delete();
    rsp_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.flush_req = 1'b0;
    cycle(2);
    rst = 1'b0;
    cycle(1);
    clear_logs();
  endtask

  task automatic expect_rsp(input string tag, input int id, input int data, input int err);
    check_eq({tag, "_present"}, rsp_id_q.size() > 0, 1);
    if (rsp_id_q.size() > 0) begin
      check_eq({tag, "_id"}, rsp_id_q.pop_front(), id);
      check_eq({tag, "_data"}, rsp_data_q.pop_front(), data);
      check_eq({tag, "_err"}, rsp_err_q.pop_front(), err);
      void'(rsp_cyc_q.pop_front());
    end
  endtask

  function automatic logic [16:0] pins();
    return {bus.alsu_opcode, bus.alsu_a, bus.alsu_b, bus.alsu_cin, bus.alsu_flags};
  endfunction

  localparam logic [16:0] NopPins = 17'b000_000_000_00_001000;

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_cin    = '0;
    bus.req_flags  = '0;
    bus.flush_req  = 1'b0;
    cycle(2);

    // Reset state: pointer at NUM_REQ-1 so requester 0 wins.
    bus.req_valid = '1;
    #1;
    check_eq("rst_ready", bus.req_ready, 4'b0001);
    check_eq("rst_alsu_pins", pins(), 17'd0);
    check_eq("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err}, 0);
    check_eq("rst_flush_done", bus.flush_done, 0);
    bus.req_valid = '0;
    rst           = 1'b0;
    cycle(1);
    check_eq("idle_nop", pins(), NopPins);
    clear_logs();

    // 1: single OR from requester 0.
    set_cmd(0, 3'd0, 3'b010, 3'b001, 2'd0, 6'd0);
    bus.req_valid = 4'b0001;
    #1;
    check_eq("t1_ready", bus.req_ready, 4'b0001);
    cycle();
    bus.req_valid = '0;
    #1;
    check_eq("t1_issue", pins(), 17'b000_010_001_00_000000);
    cycle(2);
    check_eq("t1_rsp_early", bus.rsp_valid, 0);
    cycle();
    check_eq("t1_rsp_valid", bus.rsp_valid, 1);
    check_eq("t1_rsp_id", bus.rsp_id, 0);
    check_eq("t1_rsp_data", bus.rsp_data, 6'd3);
    check_eq("t1_rsp_err", bus.rsp_err, 0);
    cycle();
    check_eq("t1_rsp_one_cycle", bus.rsp_valid, 0);

    // 2: all requesters valid for 8 cycles -> strict rotation.
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) set_cmd(r, 3'd0, 3'(r), 3'd0, 2'd0, 6'd0);
    bus.req_valid = '1;
    cycle(8);
    bus.req_valid = '0;
    cycle(6);
    check_eq("t2_gnt_count", gnt_q.size(), 8);
    for (int k = 0; k < gnt_q.size() && k < 8; k++)
      check_eq($sformatf("t2_gnt%0d", k), gnt_q[k], k % 4);
    check_eq("t2_rsp_count", rsp_id_q.size(), 8);
    for (int k = 0; k < rsp_id_q.size() && k < 8; k++) begin
      check_eq($sformatf("t2_rsp_id%0d", k), rsp_id_q[k], k % 4);
      check_eq($sformatf("t2_rsp_data%0d", k), rsp_data_q[k], k % 4);
      if (k > 0) check_eq($sformatf("t2_b2b%0d", k), rsp_cyc_q[k], rsp_cyc_q[0] + k);
    end
    clear_logs();

    // 3: ADD with a reduction flag is invalid; bypass_A makes it legal.
    set_cmd(2, 3'd2, 3'd1, 3'd1, 2'd0, 6'b100000);
    bus.req_valid = 4'b0100;
    #1;
    check_eq("t3_ready", bus.req_ready, 4'b0100);
    cycle();
    bus.req_valid = '0;
    #1;
`ifdef ALSU_SCHED_ERR_FILTER_EN
    check_eq("t3_issue_flags", bus.alsu_flags, 6'b001000);
`else
    check_eq("t3_issue_flags", bus.alsu_flags, 6'b100000);
`endif
    cycle(4);
    expect_rsp("t3_bad", 2, 0, 1);
    set_cmd(2, 3'd2, 3'd3, 3'd1, 2'd0, 6'b101000);
    bus.req_valid = 4'b0100;
    cycle();
    bus.req_valid = '0;
    cycle(4);
    expect_rsp("t3_byp", 2, 3, 0);
    clear_logs();

    // 4: flush with two commands in flight.
    set_cmd(0, 3'd0, 3'b001, 3'd0, 2'd0, 6'd0);
    set_cmd(1, 3'd0, 3'b010, 3'd0, 2'd0, 6'd0);
    bus.req_valid = 4'b0011;
    cycle(2);
    bus.req_valid = 4'b1100;
    bus.flush_req = 1'b1;
    #1;
    check_eq("t4_flush_rise_block", bus.req_ready, 0);
    gnt_q.delete();
    cycle(2);
    check_eq("t4_done_early", bus.flush_done, 0);
    cycle();
    check_eq("t4_last_rsp", bus.rsp_valid, 1);
    check_eq("t4_done_at_last_rsp", bus.flush_done, 0);
    cycle();
    check_eq("t4_done", bus.flush_done, 1);
    cycle(2);
    check_eq("t4_done_held", bus.flush_done, 1);
    check_eq("t4_no_grants", gnt_q.size(), 0);
    bus.flush_req = 1'b0;
    #1;
    check_eq("t4_done_drop", bus.flush_done, 0);
    check_eq("t4_hold_ready", bus.req_ready, 0);
    cycle();
    check_eq("t4_resume", bus.req_ready, 4'b0100);
    bus.req_valid = '0;
    expect_rsp("t4_rsp0", 0, 1, 0);
    expect_rsp("t4_rsp1", 1, 2, 0);
    clear_logs();

    // 5: reset one cycle after an accept discards the in-flight tag.
    set_cmd(2, 3'd0, 3'd1, 3'd0, 2'd0, 6'd0);
    bus.req_valid = 4'b0100;
    #1;
    check_eq("t5_ready", bus.req_ready, 4'b0100);
    cycle();
    bus.req_valid = '0;
    rst           = 1'b1;
    cycle();
    rst = 1'b0;
    cycle(5);
    check_eq("t5_no_rsp", rsp_id_q.size(), 0);
    bus.req_valid = '1;
    #1;
    check_eq("t5_first_after_rst", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    clear_logs();

    // 6: requester 3 alone, then requester 1 (wrap from pointer 3).
    set_cmd(3, 3'd0, 3'd1, 3'd0, 2'd0, 6'd0);
    set_cmd(1, 3'd1, 3'd3, 3'd1, 2'd0, 6'd0);
    bus.req_valid = 4'b1000;
    #1;
    check_eq("t6_ready3", bus.req_ready, 4'b1000);
    cycle();
    bus.req_valid = '0;
    #1;
    check_eq("t6_ready3_drop", bus.req_ready, 0);
    bus.req_valid = 4'b0010;
    #1;
    check_eq("t6_ready1", bus.req_ready, 4'b0010);
    cycle();
    bus.req_valid = '0;
    #1;
    check_eq("t6_ready1_drop", bus.req_ready, 0);
    check_eq("t6_issue1", pins(), 17'b001_011_001_00_000000);
    cycle();
    check_eq("t6_idle_nop", pins(), NopPins);
    check_eq("t6_gnt_count", gnt_q.size(), 2);
    if (gnt_q.size() == 2) begin
      check_eq("t6_gnt0", gnt_q[0], 3);
      check_eq("t6_gnt1", gnt_q[1], 1);
    end
    cycle(4);
    expect_rsp("t6_rsp3", 3, 1, 0);
    expect_rsp("t6_rsp1", 1, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
